// File: rtl/muldiv_hilo_unit.sv
// Iterative signed mult/div that owns HI/LO and serves mfhi/mflo/mthi/mtlo.
// 33 busy cycles per op (1 for div-by-zero); stall_req holds the front-end while busy.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic [3:0]       alusignal,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             read_req,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall_req
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  localparam logic [3:0]       ALU_MULT = 4'b1001;
  localparam logic [3:0]       ALU_DIV  = 4'b1111;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t               r_state, w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_is_div, r_sign_a, r_sign_b;
  logic [WIDTH-1:0]     r_opnd;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_hi, r_lo;
  logic                 r_done;

  logic                 w_start, w_start_div, w_div0;
  logic                 w_busy, w_fix, w_idle;
  logic [WIDTH-1:0]     w_abs_a, w_abs_b;
  logic [WIDTH:0]       w_madd;
  logic [2*WIDTH-1:0]   w_mul_nxt, w_div_nxt, w_prod;
  logic [WIDTH:0]       w_dup;
  logic                 w_dge;
  logic [WIDTH-1:0]     w_dsub, w_quot, w_rem;

  assign w_start     = ex_valid & ((alusignal == ALU_MULT) | (alusignal == ALU_DIV));
  assign w_start_div = (alusignal == ALU_DIV);
  assign w_div0      = w_start_div & (b == '0);
  assign w_abs_a     = a[WIDTH-1] ? ('0 - a) : a;
  assign w_abs_b     = b[WIDTH-1] ? ('0 - b) : b;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = w_div0 ? S_FIX : S_RUN;
      S_RUN:   if (r_cnt == CNT_LAST) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_fix  = 1'b0;
    w_idle = 1'b0;
    case (r_state)
      S_IDLE:  w_idle = 1'b1;
      S_RUN:   w_busy = 1'b1;
      S_FIX:   begin w_busy = 1'b1; w_fix = 1'b1; end
      default: w_idle = 1'b1;
    endcase
  end

  // Mult: acc = {partial, multiplier}; add multiplicand on LSB then shift right.
  assign w_madd    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_nxt = {w_madd, r_acc[WIDTH-1:1]};

  // Div: acc = {remainder, dividend}; shift left, subtract divisor when it fits.
  assign w_dup     = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_dge     = (w_dup >= {1'b0, r_opnd});
  assign w_dsub    = w_dup[WIDTH-1:0] - r_opnd;
  assign w_div_nxt = {(w_dge ? w_dsub : w_dup[WIDTH-1:0]), r_acc[WIDTH-2:0], w_dge};

  assign w_prod = (r_sign_a ^ r_sign_b) ? ('0 - r_acc) : r_acc;
  assign w_quot = (r_sign_a ^ r_sign_b) ? ('0 - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
  assign w_rem  = r_sign_a ? ('0 - r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_fix;
      if (w_idle) begin
        if (w_start) begin
          r_is_div <= w_start_div;
          r_sign_a <= a[WIDTH-1];
          r_sign_b <= b[WIDTH-1];
          r_cnt    <= '0;
          if (w_start_div) begin
            r_opnd <= w_abs_b;
            r_acc  <= w_div0 ? '0 : {{WIDTH{1'b0}}, w_abs_a};
          end else begin
            r_opnd <= w_abs_a;
            r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
          end
        end else begin
          if (mthi_we) r_hi <= wdata;
          if (mtlo_we) r_lo <= wdata;
        end
      end else if (w_fix) begin
        if (r_is_div) begin
          r_hi <= w_rem;
          r_lo <= w_quot;
        end else begin
          r_hi <= w_prod[2*WIDTH-1:WIDTH];
          r_lo <= w_prod[WIDTH-1:0];
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
      end
    end
  end

  assign hi        = r_hi;
  assign lo        = r_lo;
  assign busy      = w_busy;
  assign done      = r_done;
  assign stall_req = w_busy & (read_req | w_start | mthi_we | mtlo_we);

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench for muldiv_hilo_unit: vector table plus hand sequences for reset/mt*/back-to-back.
module tb_muldiv_hilo_unit;

  logic        clk = 1'b0;
  logic        reset, ex_valid, read_req, mthi_we, mtlo_we;
  logic [3:0]  alusignal;
  logic [31:0] a, b, wdata, hi, lo;
  logic        busy, done, stall_req;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [3:0] OP_MUL = 4'b1001;
  localparam logic [3:0] OP_DIV = 4'b1111;

  muldiv_hilo_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .alusignal(alusignal),
    .a(a), .b(b), .read_req(read_req), .mthi_we(mthi_we), .mtlo_we(mtlo_we),
    .wdata(wdata), .hi(hi), .lo(lo), .busy(busy), .done(done), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          ebusy;
    bit          rd;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output bit ok);
    int g;
    g = 0;
    while (done !== 1'b1 && g < 60) begin
      tick();
      g++;
    end
    ok = (done === 1'b1);
  endtask

  // Called at a sample point with the unit idle; returns in the done cycle.
  task automatic do_op(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                       input bit rd, output int bcnt, output bit hold_ok,
                       output bit stall_ok, output bit dn_ok);
    logic [31:0] oh, ol;
    int g;
    oh = hi; ol = lo;
    ex_valid = 1'b1; alusignal = op; a = va; b = vb;
    #1;
    stall_ok = (stall_req === 1'b0);
    tick();
    ex_valid = 1'b0; alusignal = 4'b0000; a = $urandom; b = $urandom; read_req = rd;
    bcnt = 0; hold_ok = 1'b1; g = 0;
    #1;
    while (done !== 1'b1 && g < 60) begin
      if (busy === 1'b1) bcnt++;
      if (hi !== oh || lo !== ol) hold_ok = 1'b0;
      if (stall_req !== (busy & rd)) stall_ok = 1'b0;
      tick();
      g++;
    end
    dn_ok = (done === 1'b1) && (busy === 1'b0);
    if (stall_req !== 1'b0) stall_ok = 1'b0;
    read_req = 1'b0;
  endtask

  initial begin
    int  bc;
    bit  h_ok, s_ok, d_ok, ok;
    logic [31:0] keep;

    tbl[0]  = '{OP_MUL, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 1'b0};
    tbl[1]  = '{OP_DIV, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0};
    tbl[2]  = '{OP_DIV, 32'd100,        32'd7,        32'd2,        32'd14,       33, 1'b1};
    tbl[3]  = '{OP_DIV, 32'h80000000,   32'hFFFFFFFF, 32'h0,        32'h80000000, 33, 1'b0};
    tbl[4]  = '{OP_DIV, 32'd5,          32'd0,        32'h0,        32'h0,         1, 1'b1};
    tbl[5]  = '{OP_MUL, 32'h7FFFFFFF,   32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 33, 1'b1};
    tbl[6]  = '{OP_MUL, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h0,        32'h1,        33, 1'b0};
    tbl[7]  = '{OP_DIV, 32'd7,          32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 33, 1'b0};
    tbl[8]  = '{OP_MUL, 32'h80000000,   32'h80000000, 32'h40000000, 32'h0,        33, 1'b0};
    tbl[9]  = '{OP_MUL, 32'h12345678,   32'h0,        32'h0,        32'h0,        33, 1'b0};
    tbl[10] = '{OP_DIV, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       33, 1'b1};
    tbl[11] = '{OP_MUL, 32'h00010000,   32'h00010000, 32'h1,        32'h0,        33, 1'b0};
    tbl[12] = '{OP_DIV, 32'd0,          32'd5,        32'h0,        32'h0,        33, 1'b0};
    tbl[13] = '{OP_DIV, 32'hFFFFFFF9,   32'd0,        32'h0,        32'h0,         1, 1'b0};

    reset = 1'b1; ex_valid = 1'b0; alusignal = 4'b0; a = '0; b = '0;
    read_req = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0; wdata = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    read_req = 1'b1; mthi_we = 1'b1; mtlo_we = 1'b1; #1;
    chk("rst_stall_idle", {31'b0, stall_req}, 32'h0);
    mthi_we = 1'b0; mtlo_we = 1'b0; read_req = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) begin
      do_op(tbl[i].op, tbl[i].va, tbl[i].vb, tbl[i].rd, bc, h_ok, s_ok, d_ok);
      chk($sformatf("v%0d_done", i), {31'b0, d_ok}, 32'h1);
      chk($sformatf("v%0d_hi", i), hi, tbl[i].ehi);
      chk($sformatf("v%0d_lo", i), lo, tbl[i].elo);
      chk($sformatf("v%0d_busycnt", i), bc, tbl[i].ebusy);
      chk($sformatf("v%0d_hold", i), {31'b0, h_ok}, 32'h1);
      chk($sformatf("v%0d_stall", i), {31'b0, s_ok}, 32'h1);
      tick();
      chk($sformatf("v%0d_done_1cyc", i), {31'b0, done}, 32'h0);
    end

    // mthi alone, then both in the same cycle
    mthi_we = 1'b1; wdata = 32'hDEADBEEF; tick(); mthi_we = 1'b0;
    chk("mthi", hi, 32'hDEADBEEF);
    mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'h00000055; tick();
    mthi_we = 1'b0; mtlo_we = 1'b0;
    chk("mt_both_hi", hi, 32'h55);
    chk("mt_both_lo", lo, 32'h55);

    // mtlo during RUN is stalled and not applied
    ex_valid = 1'b1; alusignal = OP_MUL; a = 32'd2; b = 32'd3; tick();
    ex_valid = 1'b0; alusignal = 4'b0;
    mtlo_we = 1'b1; wdata = 32'h0000AAAA; #1;
    chk("mt_run_stall", {31'b0, stall_req}, 32'h1);
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (lo !== 32'h55 || stall_req !== 1'b1) ok = 1'b0;
    end
    mtlo_we = 1'b0;
    chk("mt_run_lo_hold", {31'b0, ok}, 32'h1);
    wait_done(ok);
    chk("mt_run_done", {31'b0, ok}, 32'h1);
    chk("mt_run_lo", lo, 32'd6);
    chk("mt_run_hi", hi, 32'd0);

    // Back-to-back start in the done cycle, combined with mtlo in IDLE (dropped)
    ex_valid = 1'b1; alusignal = OP_MUL; a = 32'd1; b = 32'd9;
    mtlo_we = 1'b1; wdata = 32'h00001234; tick();
    ex_valid = 1'b0; alusignal = 4'b0; mtlo_we = 1'b0;
    chk("b2b_busy", {31'b0, busy}, 32'h1);
    chk("start_mt_drop", lo, 32'd6);
    wait_done(ok);
    chk("b2b_done", {31'b0, ok}, 32'h1);
    chk("b2b_lo", lo, 32'd9);

    // Reset mid-operation
    mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'h0BADF00D; tick();
    mthi_we = 1'b0; mtlo_we = 1'b0;
    ex_valid = 1'b1; alusignal = OP_MUL; a = 32'd11; b = 32'd13; tick();
    ex_valid = 1'b0; alusignal = 4'b0;
    for (int k = 0; k < 9; k++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) ok = 1'b1;
      tick();
    end
    chk("abort_no_done", {31'b0, ok}, 32'h0);
    do_op(OP_MUL, 32'hFFFFFFFC, 32'd5, 1'b0, bc, h_ok, s_ok, d_ok);
    chk("post_rst_done", {31'b0, d_ok}, 32'h1);
    chk("post_rst_hi", hi, 32'hFFFFFFFF);
    chk("post_rst_lo", lo, 32'hFFFFFFEC);
    keep = {31'b0, s_ok};
    chk("post_rst_stall", keep, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Multi-cycle sequential owner of the architectural HI/LO registers.
- Receives signed mult/div requests from the EX stage, using the same alusignal encodings as the EX ALU: 4'b1001 mult, 4'b1111 div.
- Computes iteratively and writes HI/LO on completion.
- Serves mfhi/mflo/mthi/mtlo, and raises a stall request to the hazard unit while a result is pending.

Parameters:
- WIDTH, 32, operand width and width of HI/LO.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- ex_valid  input  1  EX stage holds a valid instruction this cycle.
- alusignal  input  4  EX ALU control; 4'b1001 = mult, 4'b1111 = div, all other values = no request.
- a  input  WIDTH  signed operand rs (multiplicand / dividend).
- b  input  WIDTH  signed operand rt (multiplier / divisor).
- read_req  input  1  mfhi/mflo in EX needs HI/LO this cycle.
- mthi_we  input  1  write wdata to HI.
- mtlo_we  input  1  write wdata to LO.
- wdata  input  WIDTH  mthi/mtlo data.
- hi  output  WIDTH  HI register (remainder / product[63:32]).
- lo  output  WIDTH  LO register (quotient / product[31:0]).
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: HI/LO just updated by mult/div.
- stall_req  output  1  hold the pipeline front-end.

Behaviour:
- Reset (sync, on clk edge with reset=1):
  - State=IDLE, counter=0, internal accumulators=0.
  - hi=0, lo=0, busy=0, done=0.
  - Reset mid-operation aborts it: HI/LO are cleared, no done pulse.
- start = ex_valid & (alusignal==4'b1001 | alusignal==4'b1111). Sampled only in IDLE.
- States: IDLE, RUN, FIX.
- IDLE, start sampled:
  - Latch |a|, |b|, sign flags and op; counter=0.
  - Next state RUN.
  - Exception: div with b==0 goes straight to FIX with a zero result.
- RUN: one iteration per cycle.
  - Mult: shift-add on unsigned magnitudes into a 2*WIDTH accumulator.
  - Div: restoring shift-subtract, 1 quotient bit per cycle.
  - Counter increments; after the iteration at counter==WIDTH-1, next state FIX.
- FIX: apply signs, write HI/LO at the edge, return to IDLE.
  - Mult: product negated (two's complement, 2*WIDTH) if sign(a)!=sign(b); hi=p[63:32], lo=p[31:0].
  - Div: quotient negated if sign(a)!=sign(b); remainder takes the sign of a (C/Verilog truncating semantics); lo=quotient, hi=remainder.
  - Div by zero: hi=0, lo=0.
  - Overflow -2^31 / -1: lo=32'h80000000, hi=0.
- Timing, with start sampled at edge N:
  - Normal op: RUN for edges N+1..N+32, FIX at edge N+33. hi/lo hold new values from the cycle after edge N+33.
  - Done pulses high in that same cycle, for exactly one cycle.
  - Div by zero: FIX at edge N+1; done in the cycle after edge N+1.
- busy: 1 in RUN and FIX, 0 in IDLE. done is registered and never coincides with busy=1 for the same op.
- stall_req (combinational): busy & (read_req | start | mthi_we | mtlo_we). Zero in IDLE.
- New request while busy: a start, mthi_we or mtlo_we seen while busy is not accepted. The pipeline is stalled and re-presents it; the in-flight op is unaffected.
- mthi/mtlo:
  - In IDLE without start, hi/lo are written at the edge.
  - Both may be written in the same cycle.
  - If start and mt*_we are asserted together in IDLE, start wins and the mt* write is dropped.
- Reads: hi/lo are stable outputs during RUN and FIX, holding the old values until the FIX edge. read_req has no side effect on state.
- Operands a/b may change after the start cycle without effect.
- Back-to-back: a start presented in the done cycle is accepted (state is IDLE).

Test Plan:
- mult a=7, b=-3 (32'hFFFFFFFD) at edge N -> busy 1 for 33 cycles; hi=32'hFFFFFFFF, lo=32'hFFFFFFEB, done pulse one cycle after edge N+33.
- div a=-7, b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1); div a=100, b=7 -> lo=14, hi=2; div a=32'h80000000, b=-1 -> lo=32'h80000000, hi=0.
- div a=5, b=0 -> hi=0, lo=0; busy exactly 1 cycle; done one cycle after edge N+1.
- mult 32'h7FFFFFFF * 32'h7FFFFFFF, then read_req held high from cycle N+1 -> stall_req=1 every busy cycle, 0 in the done cycle; hi=32'h3FFFFFFF, lo=32'h00000001.
- reset=1 at cycle N+10 of a mult -> next cycle busy=0, hi=lo=0, no done pulse ever; new mult afterwards completes normally.
- IDLE: mthi_we=1, wdata=32'hDEADBEEF -> hi=32'hDEADBEEF next cycle. mtlo_we asserted during RUN -> stall_req=1, lo unchanged until FIX. start with mtlo_we in IDLE -> mt write dropped.
